// File: rtl/robot_pkg.sv
// -----------------------------------------------------------------------------
// robot_pkg
//   Shared definitions for the light-following motor drive controller.
//   Contents:
//     drive_state_e      - FSM state encoding (IDLE=0, SEEK=1, FORWARD=2, STOP=3)
//     DEF_*              - default parameter values for the controller
//     LVL_W / LEVEL_FULL - width and full-scale value of a percent level
//     clamp_duty()       - saturates a raw duty reading to 100 percent
//     ramp_toward()      - one bounded ramp step of a level toward its target
// -----------------------------------------------------------------------------
package robot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEEK    = 2'd1,
    ST_FORWARD = 2'd2,
    ST_STOP    = 2'd3
  } drive_state_e;

  localparam int DEF_TICK_DIV       = 2500;
  localparam int DEF_PWM_PERIOD     = 100;
  localparam int DEF_LOW_THRESH     = 30;
  localparam int DEF_HIGH_THRESH    = 70;
  localparam int DEF_SEEK_LEVEL     = 60;
  localparam int DEF_RAMP_STEP      = 10;
  localparam int DEF_TIMEOUT_FRAMES = 8;

  // Levels, tick counts and frame counts all share one 8-bit width.
  localparam int               LVL_W      = 8;
  localparam logic [LVL_W-1:0] LEVEL_FULL = 8'd100;

  // Readings above full scale are treated as full scale.
  function automatic logic [LVL_W-1:0] clamp_duty(input logic [LVL_W-1:0] raw);
    logic [LVL_W-1:0] res;
    if (raw > LEVEL_FULL) begin
      res = LEVEL_FULL;
    end else begin
      res = raw;
    end
    return res;
  endfunction

  // Move cur toward tgt by at most step; the distance test happens before the
  // add/subtract so the result never passes the target or wraps.
  function automatic logic [LVL_W-1:0] ramp_toward(input logic [LVL_W-1:0] cur,
                                                   input logic [LVL_W-1:0] tgt,
                                                   input logic [LVL_W-1:0] step);
    logic [LVL_W-1:0] nxt;
    if (cur < tgt) begin
      if ((tgt - cur) > step) begin
        nxt = cur + step;
      end else begin
        nxt = tgt;
      end
    end else if (cur > tgt) begin
      if ((cur - tgt) > step) begin
        nxt = cur - step;
      end else begin
        nxt = tgt;
      end
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/motor_drive_controller_if.sv
// -----------------------------------------------------------------------------
// motor_drive_controller_if
//   Bundles the sensor input and drive outputs of the motor drive controller.
//   Signals:
//     DutyPercent [7:0] - measured light duty cycle in percent (0-100 nominal)
//     DutyValid         - one-cycle strobe qualifying DutyPercent
//     MotorSignal [1:0] - PWM drive, bit 0 left motor, bit 1 right motor
//     DriveState  [1:0] - current FSM state encoding
//   Modports:
//     master - the sensor side / environment (drives DutyPercent, DutyValid)
//     slave  - the controller (drives MotorSignal, DriveState)
// -----------------------------------------------------------------------------
interface motor_drive_controller_if;
  import robot_pkg::*;

  logic [LVL_W-1:0] DutyPercent;
  logic             DutyValid;
  logic [1:0]       MotorSignal;
  logic [1:0]       DriveState;

  modport master (
    output DutyPercent,
    output DutyValid,
    input  MotorSignal,
    input  DriveState
  );

  modport slave (
    input  DutyPercent,
    input  DutyValid,
    output MotorSignal,
    output DriveState
  );

endinterface

// File: rtl/motor_pwm_channel.sv
// -----------------------------------------------------------------------------
// motor_pwm_channel
//   One motor channel: a ramped level register plus the PWM comparator.
//   The level only moves on a frame strobe, so every frame carries one whole
//   pulse of a single width.
//   Ports:
//     clk        - clock, rising edge
//     rst        - synchronous active-high reset (level and output to 0)
//     frame_i    - one-cycle frame boundary strobe
//     tick_cnt_i - tick counter value that will be current after this edge
//     target_i   - level the ramp is heading for
//     pwm_o      - registered PWM output
// -----------------------------------------------------------------------------
module motor_pwm_channel
  import robot_pkg::*;
#(
  parameter int RAMP_STEP = DEF_RAMP_STEP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_i,
  input  logic [LVL_W-1:0] tick_cnt_i,
  input  logic [LVL_W-1:0] target_i,
  output logic             pwm_o
);

  localparam logic [LVL_W-1:0] STEP = LVL_W'(RAMP_STEP);

  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_d;
  logic             pwm_q;
  logic             pwm_d;

  // Next level and next output; comparing the next tick count against the
  // next level keeps the registered pulse aligned with the frame start.
  always_comb begin
    if (frame_i) begin
      level_d = ramp_toward(level_q, target_i, STEP);
    end else begin
      level_d = level_q;
    end
    pwm_d = (tick_cnt_i < level_d);
  end

  // Level and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 8'd0;
      pwm_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      pwm_q   <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/motor_drive_controller.sv
// -----------------------------------------------------------------------------
// motor_drive_controller
//   Light-following two-motor drive. A duty reading selects a drive state
//   (SEEK spins with the left motor only, FORWARD drives both); a lack of
//   readings for TIMEOUT_FRAMES PWM frames stops the robot. Motor levels ramp
//   toward per-state targets by at most RAMP_STEP per frame.
//   Ports:
//     InputClock - single clock, rising edge
//     Reset      - synchronous active-high reset
//     bus        - slave side of motor_drive_controller_if
//                  (DutyPercent, DutyValid in; MotorSignal, DriveState out)
// -----------------------------------------------------------------------------
module motor_drive_controller
  import robot_pkg::*;
#(
  parameter int TICK_DIV       = DEF_TICK_DIV,
  parameter int PWM_PERIOD     = DEF_PWM_PERIOD,
  parameter int LOW_THRESH     = DEF_LOW_THRESH,
  parameter int HIGH_THRESH    = DEF_HIGH_THRESH,
  parameter int SEEK_LEVEL     = DEF_SEEK_LEVEL,
  parameter int RAMP_STEP      = DEF_RAMP_STEP,
  parameter int TIMEOUT_FRAMES = DEF_TIMEOUT_FRAMES
) (
  input logic                     InputClock,
  input logic                     Reset,
  motor_drive_controller_if.slave bus
);

  // A divide-by-one prescaler still needs a one-bit counter that stays at 0.
  localparam int               PRE_W       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE     = PRE_W'(1);
  localparam logic [PRE_W-1:0] PRE_ZERO    = PRE_W'(0);
  localparam logic [LVL_W-1:0] PERIOD_LAST = LVL_W'(PWM_PERIOD - 1);
  localparam logic [LVL_W-1:0] LOW_T       = LVL_W'(LOW_THRESH);
  localparam logic [LVL_W-1:0] HIGH_T      = LVL_W'(HIGH_THRESH);
  localparam logic [LVL_W-1:0] SEEK_L      = LVL_W'(SEEK_LEVEL);
  localparam logic [LVL_W-1:0] TO_COUNT    = LVL_W'(TIMEOUT_FRAMES);

  // Input sample stage
  logic             dv_q;
  logic             dv_d;
  logic [LVL_W-1:0] duty_q;
  logic [LVL_W-1:0] duty_d;

  // Timebase
  logic [PRE_W-1:0] pre_cnt_q;
  logic [PRE_W-1:0] pre_cnt_d;
  logic [LVL_W-1:0] tick_cnt_q;
  logic [LVL_W-1:0] tick_cnt_d;
  logic             tick_s;
  logic             frame_s;

  // Drive FSM and frame timeout
  drive_state_e     state_q;
  drive_state_e     state_d;
  logic [LVL_W-1:0] frame_cnt_q;
  logic [LVL_W-1:0] frame_cnt_d;

  // Ramp targets and channel outputs
  logic [LVL_W-1:0] tgt_left_s;
  logic [LVL_W-1:0] tgt_right_s;
  logic             pwm_left_s;
  logic             pwm_right_s;

  // Capture the reading (already clamped) so the FSM acts one edge later.
  always_comb begin
    dv_d   = bus.DutyValid;
    duty_d = clamp_duty(bus.DutyPercent);
  end

  // Prescaler and tick counter; the tick-counter wrap is the frame boundary.
  always_comb begin
    tick_s = (pre_cnt_q == PRE_LAST);
    if (tick_s) begin
      pre_cnt_d = PRE_ZERO;
    end else begin
      pre_cnt_d = pre_cnt_q + PRE_ONE;
    end
    frame_s = tick_s && (tick_cnt_q == PERIOD_LAST);
    if (frame_s) begin
      tick_cnt_d = 8'd0;
    end else if (tick_s) begin
      tick_cnt_d = tick_cnt_q + 8'd1;
    end else begin
      tick_cnt_d = tick_cnt_q;
    end
  end

  // Next state. A sample always wins over a coinciding timeout and restarts
  // the frame count; the count saturates so an idle robot never wraps it.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    if (dv_q) begin
      frame_cnt_d = 8'd0;
      case (state_q)
        ST_FORWARD: begin
          if (duty_q < LOW_T) begin
            state_d = ST_SEEK;
          end else begin
            state_d = ST_FORWARD;
          end
        end
        ST_IDLE, ST_SEEK, ST_STOP: begin
          if (duty_q >= HIGH_T) begin
            state_d = ST_FORWARD;
          end else begin
            state_d = ST_SEEK;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else if (frame_s) begin
      if (frame_cnt_q < TO_COUNT) begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end else begin
        frame_cnt_d = frame_cnt_q;
      end
      if ((frame_cnt_d == TO_COUNT) &&
          ((state_q == ST_SEEK) || (state_q == ST_FORWARD))) begin
        state_d = ST_STOP;
      end else begin
        state_d = state_q;
      end
    end else begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
    end
  end

  // Per-state motor targets (left, right).
  always_comb begin
    case (state_q)
      ST_SEEK: begin
        tgt_left_s  = SEEK_L;
        tgt_right_s = 8'd0;
      end
      ST_FORWARD: begin
        tgt_left_s  = LEVEL_FULL;
        tgt_right_s = LEVEL_FULL;
      end
      ST_IDLE, ST_STOP: begin
        tgt_left_s  = 8'd0;
        tgt_right_s = 8'd0;
      end
      default: begin
        tgt_left_s  = 8'd0;
        tgt_right_s = 8'd0;
      end
    endcase
  end

  // Control registers; reset also discards any reading presented with it.
  always_ff @(posedge InputClock) begin
    if (Reset) begin
      dv_q        <= 1'b0;
      duty_q      <= 8'd0;
      pre_cnt_q   <= PRE_ZERO;
      tick_cnt_q  <= 8'd0;
      state_q     <= ST_IDLE;
      frame_cnt_q <= 8'd0;
    end else begin
      dv_q        <= dv_d;
      duty_q      <= duty_d;
      pre_cnt_q   <= pre_cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  motor_pwm_channel #(
    .RAMP_STEP (RAMP_STEP)
  ) u_left (
    .clk        (InputClock),
    .rst        (Reset),
    .frame_i    (frame_s),
    .tick_cnt_i (tick_cnt_d),
    .target_i   (tgt_left_s),
    .pwm_o      (pwm_left_s)
  );

  motor_pwm_channel #(
    .RAMP_STEP (RAMP_STEP)
  ) u_right (
    .clk        (InputClock),
    .rst        (Reset),
    .frame_i    (frame_s),
    .tick_cnt_i (tick_cnt_d),
    .target_i   (tgt_right_s),
    .pwm_o      (pwm_right_s)
  );

  assign bus.MotorSignal = {pwm_right_s, pwm_left_s};
  assign bus.DriveState  = state_q;

endmodule

// File: tb/tb_motor_drive_controller.sv
// -----------------------------------------------------------------------------
// tb_motor_drive_controller
//   Drives the controller with TICK_DIV=1, PWM_PERIOD=100 and compares its
//   outputs every cycle against a reference model written from the drive
//   rules: position in frame = edges since reset mod 100, readings act one
//   edge after they are sampled, levels step 10 per frame toward the target.
// -----------------------------------------------------------------------------
module tb_motor_drive_controller;

  localparam int P = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;

  motor_drive_controller_if bus ();

  motor_drive_controller #(
    .TICK_DIV       (1),
    .PWM_PERIOD     (100),
    .LOW_THRESH     (30),
    .HIGH_THRESH    (70),
    .SEEK_LEVEL     (60),
    .RAMP_STEP      (10),
    .TIMEOUT_FRAMES (8)
  ) dut (
    .InputClock (clk),
    .Reset      (rst),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int m_state  = 0;
  int m_lvl [2] = '{0, 0};
  int m_cyc    = 0;
  int m_frames = 0;
  int m_pv     = 0;
  int m_pd     = 0;

  function automatic int target_of(input int st, input int n);
    int t;
    if (st == 1) t = (n == 0) ? 60 : 0;
    else if (st == 2) t = 100;
    else t = 0;
    return t;
  endfunction

  function automatic logic [1:0] exp_mot();
    int pos;
    pos = m_cyc % P;
    return {(pos < m_lvl[1]), (pos < m_lvl[0])};
  endfunction

  // Apply one cycle of inputs, advance the model at the edge, sample at +1.
  task automatic cycle(input logic r, input logic v, input int d);
    int ns;
    int dd;
    int tgt;
    bit bnd;
    rst = r;
    bus.DutyValid = v;
    bus.DutyPercent = 8'(d);
    @(posedge clk);
    if (r) begin
      m_state = 0; m_lvl[0] = 0; m_lvl[1] = 0;
      m_cyc = 0; m_frames = 0; m_pv = 0; m_pd = 0;
    end else begin
      m_cyc++;
      bnd = (m_cyc % P) == 0;
      ns = m_state;
      if (m_pv != 0) begin
        dd = (m_pd > 100) ? 100 : m_pd;
        m_frames = 0;
        if (m_state == 2) ns = (dd < 30) ? 1 : 2;
        else ns = (dd >= 70) ? 2 : 1;
      end else if (bnd) begin
        if (m_frames < 8) m_frames++;
        if (m_frames == 8 && (m_state == 1 || m_state == 2)) ns = 3;
      end
      if (bnd) begin
        for (int n = 0; n < 2; n++) begin
          tgt = target_of(m_state, n);
          if (m_lvl[n] < tgt) m_lvl[n] = (m_lvl[n] + 10 > tgt) ? tgt : m_lvl[n] + 10;
          else m_lvl[n] = (m_lvl[n] - 10 < tgt) ? tgt : m_lvl[n] - 10;
        end
      end
      m_state = ns;
      m_pv = v ? 1 : 0;
      m_pd = d;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 90);
      n_vec++;
      if (bus.MotorSignal !== 2'b00 || bus.DriveState !== 2'd0) begin
        n_err++;
        $display("FAIL reset: motor=%b state=%0d, need motor=00 state=0", bus.MotorSignal, bus.DriveState);
      end
    end
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, 0);
      n_vec++;
      if (bus.MotorSignal !== exp_mot() || bus.DriveState !== 2'(m_state)) begin
        n_err++;
        $display("FAIL reset_idle cyc=%0d: motor=%b state=%0d, need motor=%b state=%0d", m_cyc, bus.MotorSignal, bus.DriveState, exp_mot(), m_state);
      end
    end
  endtask

  task automatic test_forward_ramp();
    cycle(1'b0, 1'b1, 80);
    n_vec++;
    if (bus.DriveState !== 2'd0) begin
      n_err++;
      $display("FAIL fwd_latency0: state=%0d, need 0", bus.DriveState);
    end
    cycle(1'b0, 1'b0, 0);
    n_vec++;
    if (bus.DriveState !== 2'd2) begin
      n_err++;
      $display("FAIL fwd_latency1: state=%0d, need 2", bus.DriveState);
    end
    for (int i = 0; i < 1100; i++) begin
      cycle(1'b0, (i % 300) == 150, 80);
      n_vec++;
      if (bus.MotorSignal !== exp_mot() || bus.DriveState !== 2'(m_state)) begin
        n_err++;
        $display("FAIL fwd_ramp cyc=%0d: motor=%b state=%0d, need motor=%b state=%0d", m_cyc, bus.MotorSignal, bus.DriveState, exp_mot(), m_state);
      end
    end
    for (int i = 0; i < 100; i++) begin
      cycle(1'b0, i == 50, 80);
      n_vec++;
      if (bus.MotorSignal !== 2'b11) begin
        n_err++;
        $display("FAIL fwd_full cyc=%0d: motor=%b, need 11", m_cyc, bus.MotorSignal);
      end
    end
  endtask

  task automatic test_hysteresis();
    int hl;
    int hr;
    cycle(1'b0, 1'b1, 50);
    cycle(1'b0, 1'b0, 0);
    cycle(1'b0, 1'b0, 0);
    n_vec++;
    if (bus.DriveState !== 2'd2) begin
      n_err++;
      $display("FAIL hyst_hold: state=%0d, need 2", bus.DriveState);
    end
    cycle(1'b0, 1'b1, 20);
    cycle(1'b0, 1'b0, 0);
    n_vec++;
    if (bus.DriveState !== 2'd1) begin
      n_err++;
      $display("FAIL hyst_seek: state=%0d, need 1", bus.DriveState);
    end
    for (int i = 0; i < 1300; i++) begin
      cycle(1'b0, (i % 300) == 100, 20);
      n_vec++;
      if (bus.MotorSignal !== exp_mot() || bus.DriveState !== 2'(m_state)) begin
        n_err++;
        $display("FAIL hyst_ramp cyc=%0d: motor=%b state=%0d, need motor=%b state=%0d", m_cyc, bus.MotorSignal, bus.DriveState, exp_mot(), m_state);
      end
    end
    hl = 0;
    hr = 0;
    for (int i = 0; i < P; i++) begin
      cycle(1'b0, i == 50, 20);
      hl += int'(bus.MotorSignal[0]);
      hr += int'(bus.MotorSignal[1]);
    end
    n_vec++;
    if (hl != 60 || hr != 0) begin
      n_err++;
      $display("FAIL seek_duty: left_high=%0d right_high=%0d, need 60 and 0", hl, hr);
    end
  endtask

  task automatic test_clamp();
    cycle(1'b0, 1'b1, 200);
    cycle(1'b0, 1'b0, 0);
    n_vec++;
    if (bus.DriveState !== 2'd2) begin
      n_err++;
      $display("FAIL clamp: state=%0d, need 2", bus.DriveState);
    end
    for (int i = 0; i < 50; i++) begin
      cycle(1'b0, 1'b0, 0);
      n_vec++;
      if (bus.MotorSignal !== exp_mot() || bus.DriveState !== 2'(m_state)) begin
        n_err++;
        $display("FAIL clamp_run cyc=%0d: motor=%b state=%0d, need motor=%b state=%0d", m_cyc, bus.MotorSignal, bus.DriveState, exp_mot(), m_state);
      end
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 2100; i++) begin
      cycle(1'b0, 1'b0, 0);
      n_vec++;
      if (bus.MotorSignal !== exp_mot() || bus.DriveState !== 2'(m_state)) begin
        n_err++;
        $display("FAIL timeout_run cyc=%0d: motor=%b state=%0d, need motor=%b state=%0d", m_cyc, bus.MotorSignal, bus.DriveState, exp_mot(), m_state);
      end
    end
    for (int i = 0; i < P; i++) begin
      cycle(1'b0, 1'b0, 0);
      n_vec++;
      if (bus.MotorSignal !== 2'b00 || bus.DriveState !== 2'd3) begin
        n_err++;
        $display("FAIL timeout_stop cyc=%0d: motor=%b state=%0d, need motor=00 state=3", m_cyc, bus.MotorSignal, bus.DriveState);
      end
    end
    cycle(1'b0, 1'b1, 10);
    cycle(1'b0, 1'b0, 0);
    n_vec++;
    if (bus.DriveState !== 2'd1) begin
      n_err++;
      $display("FAIL stop_to_seek: state=%0d, need 1", bus.DriveState);
    end
  endtask

  task automatic test_coincide();
    bit found;
    cycle(1'b0, 1'b1, 80);
    cycle(1'b0, 1'b0, 0);
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (m_frames == 7 && ((m_cyc + 2) % P) == 0) begin
        found = 1'b1;
      end else begin
        cycle(1'b0, 1'b0, 0);
        n_vec++;
        if (bus.MotorSignal !== exp_mot() || bus.DriveState !== 2'(m_state)) begin
          n_err++;
          $display("FAIL coincide_run cyc=%0d: motor=%b state=%0d, need motor=%b state=%0d", m_cyc, bus.MotorSignal, bus.DriveState, exp_mot(), m_state);
        end
      end
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL coincide_wait: bound expired, frames=%0d need 7", m_frames);
    end else begin
      cycle(1'b0, 1'b1, 20);
      cycle(1'b0, 1'b0, 0);
      if (bus.DriveState !== 2'd1) begin
        n_err++;
        $display("FAIL coincide: state=%0d, need 1", bus.DriveState);
      end
    end
  endtask

  task automatic test_reset_mid_ramp();
    bit found;
    cycle(1'b1, 1'b0, 0);
    cycle(1'b0, 1'b1, 90);
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      if (m_lvl[0] == 40 && (m_cyc % P) == 37) begin
        found = 1'b1;
      end else begin
        cycle(1'b0, (i % 300) == 200, 90);
        n_vec++;
        if (bus.MotorSignal !== exp_mot() || bus.DriveState !== 2'(m_state)) begin
          n_err++;
          $display("FAIL midramp_run cyc=%0d: motor=%b state=%0d, need motor=%b state=%0d", m_cyc, bus.MotorSignal, bus.DriveState, exp_mot(), m_state);
        end
      end
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL midramp_wait: bound expired, left level=%0d need 40", m_lvl[0]);
    end else begin
      cycle(1'b1, 1'b1, 90);
      if (bus.MotorSignal !== 2'b00 || bus.DriveState !== 2'd0) begin
        n_err++;
        $display("FAIL midramp_reset: motor=%b state=%0d, need motor=00 state=0", bus.MotorSignal, bus.DriveState);
      end
    end
    for (int i = 0; i < 300; i++) begin
      cycle(1'b0, 1'b0, 0);
      n_vec++;
      if (bus.MotorSignal !== 2'b00 || bus.DriveState !== 2'd0) begin
        n_err++;
        $display("FAIL midramp_after cyc=%0d: motor=%b state=%0d, need motor=00 state=0", m_cyc, bus.MotorSignal, bus.DriveState);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 1499) == 0, $urandom_range(0, 59) == 0, int'($urandom_range(0, 255)));
      n_vec++;
      if (bus.MotorSignal !== exp_mot() || bus.DriveState !== 2'(m_state)) begin
        n_err++;
        $display("FAIL random cyc=%0d: motor=%b state=%0d, need motor=%b state=%0d", m_cyc, bus.MotorSignal, bus.DriveState, exp_mot(), m_state);
      end
    end
  endtask

  initial begin
    bus.DutyValid = 1'b0;
    bus.DutyPercent = 8'd0;
    test_reset();
    test_forward_ramp();
    test_hysteresis();
    test_clamp();
    test_timeout();
    test_coincide();
    test_reset_mid_ramp();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
